// File: rtl/btn_pkg.sv
// Shared state encoding and default timing for the push-button conditioner.
// Default timing assumes a 50 MHz clock.
package btn_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } btn_state_e;

  // 20 ms debounce, 500 ms first repeat, 100 ms repeat period
  localparam int DEF_DEBOUNCE_CYCLES = 1_000_000;
  localparam int DEF_REPEAT_DELAY    = 25_000_000;
  localparam int DEF_REPEAT_PERIOD   = 5_000_000;
  localparam int DEF_CNT_W           = 25;

endpackage

// File: rtl/btn_debounce_if.sv
// Button pad / conditioned-output bundle between the pad side and the debouncer.
interface btn_debounce_if;
  logic btn_raw;
  logic btn_level;
  logic press_pulse;
  logic release_pulse;

  modport master (output btn_raw, input btn_level, press_pulse, release_pulse);
  modport slave  (input btn_raw, output btn_level, press_pulse, release_pulse);
endinterface

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser, asynchronous active-low reset to 0.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [1:0] vld_pipe;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_pipe <= '0;
    else        vld_pipe <= {vld_pipe[0], d};
  end

  assign q = vld_pipe[1];

endmodule

// File: rtl/btn_debounce.sv
// Push-button conditioner: synchroniser, debounce FSM, press/release strobes.
// Define BTN_REPEAT_EN to add auto-repeat press strobes while the button is held.
module btn_debounce
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
  parameter int CNT_W           = DEF_CNT_W
) (
  input logic           clk,
  input logic           rst_n,
  btn_debounce_if.slave btn
);

  if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > (1 << CNT_W) ||
      REPEAT_DELAY < 1 || REPEAT_DELAY > (1 << CNT_W) ||
      REPEAT_PERIOD < 1 || REPEAT_PERIOD > (1 << CNT_W)) begin : g_bad_cfg
    $error("btn_debounce: timing parameters do not fit CNT_W");
  end

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             btn_s;
  btn_state_e       state;
  logic [CNT_W-1:0] cnt;
  logic             level_q, press_q, rel_q;
  logic             rpt_fire;

  sync_2ff u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (btn.btn_raw),
    .q    (btn_s)
  );

`ifdef BTN_REPEAT_EN
  logic [CNT_W-1:0] rpt_cnt;
  logic             rpt_first;

  // First terminal is REPEAT_DELAY, then REPEAT_PERIOD until HELD is left.
  assign rpt_fire = (state == HELD) && btn_s &&
                    (rpt_cnt == (rpt_first ? CNT_W'(REPEAT_DELAY - 1)
                                           : CNT_W'(REPEAT_PERIOD - 1)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rpt_cnt   <= '0;
      rpt_first <= 1'b1;
    end else if (state != HELD || !btn_s) begin
      rpt_cnt   <= '0;
      rpt_first <= 1'b1;
    end else if (rpt_fire) begin
      rpt_cnt   <= '0;
      rpt_first <= 1'b0;
    end else begin
      rpt_cnt   <= rpt_cnt + 1'b1;
    end
  end
`else
  assign rpt_fire = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
    end else begin
      press_q <= 1'b0;
      rel_q   <= 1'b0;
      unique case (state)
        IDLE: begin
          if (btn_s) begin
            state <= PRESS_WAIT;
            cnt   <= '0;
          end
        end
        PRESS_WAIT: begin
          if (!btn_s) begin
            state <= IDLE;
          end else if (cnt == DB_LAST) begin
            state   <= HELD;
            level_q <= 1'b1;
            press_q <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        HELD: begin
          if (!btn_s) begin
            state <= RELEASE_WAIT;
            cnt   <= '0;
          end else if (rpt_fire) begin
            press_q <= 1'b1;
          end
        end
        RELEASE_WAIT: begin
          // Bouncing back keeps the level high and restarts the hold phase.
          if (btn_s) begin
            state <= HELD;
          end else if (cnt == DB_LAST) begin
            state   <= IDLE;
            level_q <= 1'b0;
            rel_q   <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
      endcase
    end
  end

  assign btn.btn_level     = level_q;
  assign btn.press_pulse   = press_q;
  assign btn.release_pulse = rel_q;

endmodule

// File: tb/tb_btn_debounce.sv
// Directed bench for btn_debounce (DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3).
module tb_btn_debounce;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  btn_debounce_if bif ();

  btn_debounce #(
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY   (10),
    .REPEAT_PERIOD  (3),
    .CNT_W          (4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .btn  (bif)
  );

  int checks = 0;
  int errors = 0;

  // Downstream LFSR advanced by press_pulse as a clock enable.
  logic [7:0] lfsr;
  logic       lfsr_clr = 1'b0;
  always @(posedge clk) begin
    if (lfsr_clr)             lfsr <= 8'h01;
    else if (bif.press_pulse) lfsr <= {lfsr[0] ^ lfsr[4] ^ lfsr[7], lfsr[7:1]};
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle(input int n);
    repeat (n) tick();
  endtask

  task automatic test_reset();
    bif.btn_raw = 1'b0;
    rst_n = 1'b0;
    tick();
    checks++;
    if ({bif.btn_level, bif.press_pulse, bif.release_pulse} !== 3'b000) begin
      errors++;
      $display("FAIL reset_outputs got %b want 000",
               {bif.btn_level, bif.press_pulse, bif.release_pulse});
    end
    tick();
    rst_n = 1'b1;
    settle(4);
    checks++;
    if ({bif.btn_level, bif.press_pulse, bif.release_pulse} !== 3'b000) begin
      errors++;
      $display("FAIL post_reset_idle got %b want 000",
               {bif.btn_level, bif.press_pulse, bif.release_pulse});
    end
  endtask

  task automatic test_clean_press();
    bif.btn_raw = 1'b1;
    for (int e = 0; e <= 8; e++) begin
      tick();
      checks++;
      if (bif.press_pulse !== (e == 6) || bif.btn_level !== (e >= 6) ||
          bif.release_pulse !== 1'b0) begin
        errors++;
        $display("FAIL clean_press edge %0d got lvl/prs/rel %b%b%b want %b%b0", e,
                 bif.btn_level, bif.press_pulse, bif.release_pulse, e >= 6, e == 6);
      end
    end
  endtask

  task automatic test_release();
    bif.btn_raw = 1'b0;
    settle(2);
    bif.btn_raw = 1'b1;
    for (int e = 0; e < 10; e++) begin
      tick();
      checks++;
      if (bif.btn_level !== 1'b1 || bif.release_pulse !== 1'b0) begin
        errors++;
        $display("FAIL release_glitch edge %0d got lvl/rel %b%b want 10", e,
                 bif.btn_level, bif.release_pulse);
      end
    end
    bif.btn_raw = 1'b0;
    for (int e = 0; e <= 8; e++) begin
      tick();
      checks++;
      if (bif.release_pulse !== (e == 6) || bif.btn_level !== (e < 6) ||
          bif.press_pulse !== 1'b0) begin
        errors++;
        $display("FAIL release edge %0d got lvl/prs/rel %b%b%b want %b0%b", e,
                 bif.btn_level, bif.press_pulse, bif.release_pulse, e < 6, e == 6);
      end
    end
  endtask

  task automatic test_bounce();
    logic [11:0] pat_short = 12'b0000_0000_0111;  // bit e drives edge e
    logic [11:0] pat_tog   = 12'b0000_0101_0101;
    for (int p = 0; p < 2; p++) begin
      for (int e = 0; e < 12; e++) begin
        bif.btn_raw = (p == 0) ? pat_short[e] : pat_tog[e];
        tick();
        checks++;
        if ({bif.btn_level, bif.press_pulse, bif.release_pulse} !== 3'b000) begin
          errors++;
          $display("FAIL bounce_%0d edge %0d got lvl/prs/rel %b want 000", p, e,
                   {bif.btn_level, bif.press_pulse, bif.release_pulse});
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    bif.btn_raw = 1'b1;
    settle(8);
    rst_n = 1'b0;
    #2;
    checks++;
    if (bif.btn_level !== 1'b0) begin
      errors++;
      $display("FAIL reset_held got lvl %b want 0", bif.btn_level);
    end
    tick();
    rst_n = 1'b1;
    settle(5);  // PRESS_WAIT with cnt=2
    rst_n = 1'b0;
    #2;
    for (int e = 0; e < 3; e++) begin
      checks++;
      if ({bif.btn_level, bif.press_pulse, bif.release_pulse} !== 3'b000) begin
        errors++;
        $display("FAIL reset_wait step %0d got lvl/prs/rel %b want 000", e,
                 {bif.btn_level, bif.press_pulse, bif.release_pulse});
      end
      tick();
    end
    rst_n = 1'b1;
    for (int e = 0; e <= 8; e++) begin
      tick();
      checks++;
      if (bif.press_pulse !== (e == 6) || bif.btn_level !== (e >= 6)) begin
        errors++;
        $display("FAIL reset_rearm edge %0d got lvl/prs %b%b want %b%b", e,
                 bif.btn_level, bif.press_pulse, e >= 6, e == 6);
      end
    end
    bif.btn_raw = 1'b0;
    settle(8);
  endtask

  task automatic test_repeat();
    logic exp;
    bif.btn_raw = 1'b1;
    for (int e = 0; e <= 36; e++) begin
      int k;
      tick();
      k = e - 6;
`ifdef BTN_REPEAT_EN
      exp = (k == 0) || (k >= 10 && ((k - 10) % 3) == 0);
`else
      exp = (k == 0);
`endif
      checks++;
      if (bif.press_pulse !== exp) begin
        errors++;
        $display("FAIL repeat offset %0d got prs %b want %b", k, bif.press_pulse, exp);
      end
    end
    bif.btn_raw = 1'b0;
    settle(8);
  endtask

  task automatic test_lfsr();
    logic [7:0] exp_tab [5] = '{8'h80, 8'hC0, 8'hE0, 8'hF0, 8'h78};
    logic [7:0] prev;
    lfsr_clr = 1'b1;
    tick();
    lfsr_clr = 1'b0;
    prev = 8'h01;
    for (int i = 0; i < 5; i++) begin
      bif.btn_raw = 1'b1;
      settle(2);
      bif.btn_raw = 1'b0;
      settle(4);
      checks++;
      if (lfsr !== prev) begin
        errors++;
        $display("FAIL lfsr_bounce %0d got %h want %h", i, lfsr, prev);
      end
      bif.btn_raw = 1'b1;
      settle(8);
      bif.btn_raw = 1'b0;
      settle(8);
      checks++;
      if (lfsr !== exp_tab[i]) begin
        errors++;
        $display("FAIL lfsr_step %0d got %h want %h", i, lfsr, exp_tab[i]);
      end
      prev = exp_tab[i];
    end
  endtask

  initial begin
    bif.btn_raw = 1'b0;
    test_reset();
    test_clean_press();
    test_release();
    test_bounce();
    test_reset_mid();
    test_repeat();
    test_lfsr();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
